// File: rtl/fifo_pkg.sv
// ============================================================================
// Module      : fifo_pkg
// Description : Shared constants and helper function for the sync_fifo family.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_pkg;

    localparam int c_DEFAULT_WIDTH = 8;
    localparam int c_DEFAULT_DEPTH = 4;

    // Ceiling log2, usable in parameter and port-width expressions.
    function automatic int clog2(input int value);
        int result;
        int remain;
        result = 0;
        remain = value - 1;
        while (remain > 0) begin
            result = result + 1;
            remain = remain >> 1;
        end
        return result;
    endfunction

endpackage : fifo_pkg

`default_nettype wire

// File: rtl/sync_fifo_mem.sv
// ============================================================================
// Module      : sync_fifo_mem
// Description : DEPTH x WIDTH storage, one write port, one registered read port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo_mem
    import fifo_pkg::*;
#(
    parameter int WIDTH  = c_DEFAULT_WIDTH,
    parameter int DEPTH  = c_DEFAULT_DEPTH,
    parameter int ADDR_W = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]  i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [WIDTH-1:0]  o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;

    // Storage is deliberately left unreset; the control logic never exposes stale entries.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Read-before-write: a read and write to the same address return the old word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule : sync_fifo_mem

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with count, status flags and error pulses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo
    import fifo_pkg::*;
#(
    parameter int WIDTH     = c_DEFAULT_WIDTH,
    parameter int DEPTH     = c_DEFAULT_DEPTH,
    parameter int AFULL_LVL = DEPTH - 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_e,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_e,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       rd_valid,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic [clog2(DEPTH+1)-1:0]  count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int PTR_W = clog2(DEPTH);
    localparam int CNT_W = clog2(DEPTH + 1);

    localparam logic [CNT_W-1:0] c_FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] c_AFULL_CNT = CNT_W'(AFULL_LVL);

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_rd_valid;
    logic             r_overflow;
    logic             r_underflow;

    logic w_full;
    logic w_empty;
    logic w_wr_ok;
    logic w_rd_ok;

    // Flags decode only the registered count, so request inputs never reach them.
    assign w_full  = (r_count == c_FULL_CNT);
    assign w_empty = (r_count == '0);

    // A full FIFO still takes a write when a read frees a slot on the same edge.
    assign w_rd_ok = rd_e & ~w_empty;
    assign w_wr_ok = wr_e & (~w_full | w_rd_ok);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_rd_valid  <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            r_rd_valid  <= w_rd_ok;
            r_overflow  <= wr_e & ~w_wr_ok;
            r_underflow <= rd_e & ~w_rd_ok;
        end
    end

    sync_fifo_mem #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_mem (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_wr_ok & ~rst),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (wr_data),
        .i_rd_en   (w_rd_ok & ~rst),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (rd_data)
    );

    assign rd_valid    = r_rd_valid;
    assign full        = w_full;
    assign empty       = w_empty;
    assign almost_full = (r_count >= c_AFULL_CNT);
    assign count       = r_count;
    assign overflow    = r_overflow;
    assign underflow   = r_underflow;

endmodule : sync_fifo

`default_nettype wire

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: data word width in bits, legal values 1 or more.
REQ-002 The block SHALL have parameter DEPTH, default 4: number of entries, a power of two, 2 or more.
REQ-003 The block SHALL have parameter AFULL_LVL, default DEPTH-1: occupancy at or above which almost_full asserts, legal range 1..DEPTH.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge triggered.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port wr_e, input, 1 bit: write request.
REQ-007 The block SHALL have port wr_data, input, WIDTH bits: write data.
REQ-008 The block SHALL have port rd_e, input, 1 bit: read request.
REQ-009 The block SHALL have port rd_data, output, WIDTH bits: registered read data.
REQ-010 The block SHALL have port rd_valid, output, 1 bit: rd_data was updated by an accepted read on the previous edge.
REQ-011 The block SHALL have port full, output, 1 bit: occupancy == DEPTH.
REQ-012 The block SHALL have port empty, output, 1 bit: occupancy == 0.
REQ-013 The block SHALL have port almost_full, output, 1 bit: occupancy >= AFULL_LVL.
REQ-014 The block SHALL have port count, output, $clog2(DEPTH+1) bits: current occupancy.
REQ-015 The block SHALL have port overflow, output, 1 bit: one-cycle pulse on a rejected write.
REQ-016 The block SHALL have port underflow, output, 1 bit: one-cycle pulse on a rejected read.

Function
REQ-017 A write SHALL be accepted when wr_e=1 and (full=0, or rd_e=1 with empty=0); accepted data is stored at the write pointer.
REQ-018 A read SHALL be accepted when rd_e=1 and empty=0; the entry at the read pointer is registered into rd_data on the same edge, so latency is 1 cycle.
REQ-019 rd_valid SHALL be 1 in the cycle after an accepted read and 0 otherwise; rd_data SHALL hold its value when no read is accepted.
REQ-020 Data SHALL leave in strict write order; there is no write-to-read bypass, and a write into an empty FIFO is readable from the next cycle.
REQ-021 Read and write pointers SHALL wrap modulo DEPTH, using log2(DEPTH)-bit pointers plus an explicit count register.
REQ-022 count SHALL increment on a write-only, decrement on a read-only, and hold on both or neither; count SHALL never exceed DEPTH or go below 0.
REQ-023 Simultaneous read and write when full SHALL accept both, with count staying at DEPTH and no overflow.
REQ-024 Simultaneous read and write when empty SHALL accept the write, reject the read and pulse underflow; count becomes 1.
REQ-025 A rejected write SHALL leave memory, pointers and count unchanged and set overflow=1 for exactly the following cycle.
REQ-026 A rejected read SHALL leave rd_data, pointers and count unchanged and set underflow=1 for exactly the following cycle.
REQ-027 full, empty, almost_full and count SHALL be registered, or decoded only from registered count, with no combinational path from wr_e or rd_e.

Reset
REQ-028 While rst=1 at a clock edge: pointers=0, count=0, empty=1, full=0, almost_full=0, rd_valid=0, overflow=0, underflow=0, rd_data=0.
REQ-029 Reset SHALL take priority over simultaneous wr_e and rd_e; requests during reset are discarded with no flag pulses.
REQ-030 Memory contents SHALL NOT be reset; stale entries are unreachable after reset.
REQ-031 Reset asserted mid-operation SHALL discard all stored entries, and the first accepted write after reset is the first entry read.

Structure
REQ-032 A shared package fifo_pkg SHALL hold a clog2 helper function and the default WIDTH and DEPTH constants.
REQ-033 Storage SHALL be a sub-module sync_fifo_mem (DEPTH x WIDTH, one write port, one registered read port); control, pointers and flags stay in sync_fifo.

Verification (WIDTH=8, DEPTH=4, AFULL_LVL=3)
REQ-034 Fill/drain: write 0x11,0x22,0x33,0x44 -> full=1 and almost_full=1 after the 4th edge; four reads -> rd_data 0x11..0x44 in order with rd_valid=1 each cycle, then empty=1.
REQ-035 Overflow: when full, write 0x55 -> overflow pulses 1 cycle, count stays 4, subsequent reads return no 0x55.
REQ-036 Underflow: read when empty, including rd_e with wr_e=1 and wr_data=0x66 -> underflow pulses, count=1, next read returns 0x66.
REQ-037 Full simultaneous: while full, do read+write of 0x77 for 6 cycles -> count stays 4, no overflow, output order preserved across pointer wrap.
REQ-038 Reset mid-stream: with 3 entries held, assert rst for 1 cycle -> count=0, empty=1, rd_valid=0; write 0x99 then read -> rd_data=0x99.
